// File: rtl/cdc_edge_detect_mc_if.sv
// Signal bundle for the multi-channel trigger edge detector: trigger/control
// inputs towards the detector and the synchronised, filtered and pulse outputs.
interface cdc_edge_detect_mc_if #(
    parameter int NUM_CH    = 4,
    parameter int HOLDOFF_W = 16,
    parameter int CNT_W     = 16
);
    localparam int FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       async_in;
    logic [2*NUM_CH-1:0]     edge_type;
    logic [HOLDOFF_W-1:0]    holdoff_cycles;
    logic                    clear;
    logic [NUM_CH-1:0]       sync_out;
    logic [NUM_CH-1:0]       filt_out;
    logic [NUM_CH-1:0]       edge_pulse;
    logic                    any_pulse;
    logic [FCH_W-1:0]        first_ch;
    logic [CNT_W*NUM_CH-1:0] edge_count;
    logic [NUM_CH-1:0]       missed;

    modport master (
        output async_in, edge_type, holdoff_cycles, clear,
        input  sync_out, filt_out, edge_pulse, any_pulse, first_ch, edge_count, missed
    );

    modport slave (
        input  async_in, edge_type, holdoff_cycles, clear,
        output sync_out, filt_out, edge_pulse, any_pulse, first_ch, edge_count, missed
    );
endinterface

// File: rtl/cdc_edge_detect_mc.sv
// Multi-channel trigger front end: synchronise, glitch-filter, qualify edges,
// apply per-channel holdoff and keep saturating counts plus sticky missed flags.
module cdc_edge_detect_mc #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 2,
    parameter int HOLDOFF_W   = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cdc_edge_detect_mc_if.slave  bus
);
    localparam int FCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [FCNT_W-1:0]      fcnt_q [NUM_CH];
    logic [HOLDOFF_W-1:0]   hcnt_q [NUM_CH];
    logic [CNT_W-1:0]       cnt_q  [NUM_CH];
    logic [NUM_CH-1:0]      filt_q;
    logic [NUM_CH-1:0]      pulse_q;
    logic [NUM_CH-1:0]      missed_q;

    logic [NUM_CH-1:0]      sync_last;
    logic [NUM_CH-1:0]      toggle;
    logic [NUM_CH-1:0]      qual;
    logic [NUM_CH-1:0]      emit;
    logic [NUM_CH-1:0]      suppress;
    logic [FCH_W-1:0]       first;
    logic                   found;

    // Toggle direction is the incoming level: 1 selects the rising bit, 0 the falling bit.
    always_comb begin
        sync_last = '0;
        toggle    = '0;
        qual      = '0;
        emit      = '0;
        suppress  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sync_last[i] = sync_q[i][SYNC_STAGES-1];
            toggle[i]    = (sync_last[i] != filt_q[i]) &&
                           (fcnt_q[i] == FCNT_W'(FILTER_LEN - 1));
            qual[i]      = toggle[i] &&
                           (sync_last[i] ? bus.edge_type[2*i] : bus.edge_type[2*i+1]);
            suppress[i]  = qual[i] && (hcnt_q[i] != '0);
            emit[i]      = qual[i] && (hcnt_q[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q   <= '0;
            pulse_q  <= '0;
            missed_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= '0;
                fcnt_q[i] <= '0;
                hcnt_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            pulse_q <= emit;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.async_in[i]};

                if (sync_last[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (toggle[i]) begin
                    fcnt_q[i] <= '0;
                    filt_q[i] <= sync_last[i];
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FCNT_W'(1);
                end

                if (emit[i]) begin
                    hcnt_q[i] <= bus.holdoff_cycles;
                end else if (hcnt_q[i] != '0) begin
                    hcnt_q[i] <= hcnt_q[i] - HOLDOFF_W'(1);
                end

                // Clear wins over a same-cycle increment or missed-flag set.
                if (bus.clear) begin
                    cnt_q[i]    <= '0;
                    missed_q[i] <= 1'b0;
                end else begin
                    if (emit[i] && (cnt_q[i] != '1)) begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                    if (suppress[i]) begin
                        missed_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        first = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && pulse_q[i]) begin
                first = FCH_W'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        bus.edge_count = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.edge_count[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign bus.sync_out   = sync_last;
    assign bus.filt_out   = filt_q;
    assign bus.edge_pulse = pulse_q;
    assign bus.any_pulse  = |pulse_q;
    assign bus.first_ch   = first;
    assign bus.missed     = missed_q;
endmodule

// File: tb/tb_cdc_edge_detect_mc.sv
// Directed bench for cdc_edge_detect_mc: default-parameter instance plus a
// CNT_W=2 instance for counter saturation.
module tb_cdc_edge_detect_mc;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cdc_edge_detect_mc_if #(.NUM_CH(4), .HOLDOFF_W(16), .CNT_W(16)) bus ();
    cdc_edge_detect_mc_if #(.NUM_CH(4), .HOLDOFF_W(16), .CNT_W(2))  sb ();

    cdc_edge_detect_mc #(
        .NUM_CH(4), .SYNC_STAGES(3), .FILTER_LEN(2), .HOLDOFF_W(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    cdc_edge_detect_mc #(
        .NUM_CH(4), .SYNC_STAGES(3), .FILTER_LEN(2), .HOLDOFF_W(16), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.async_in = '0; bus.edge_type = 8'h55; bus.holdoff_cycles = '0; bus.clear = 1'b0;
        sb.async_in  = '0; sb.edge_type  = 8'h55; sb.holdoff_cycles  = '0; sb.clear  = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        checks++; if (bus.sync_out !== 4'h0) begin errors++; $display("FAIL reset_sync got %0h exp 0", bus.sync_out); end
        checks++; if (bus.filt_out !== 4'h0) begin errors++; $display("FAIL reset_filt got %0h exp 0", bus.filt_out); end
        checks++; if (bus.edge_pulse !== 4'h0) begin errors++; $display("FAIL reset_pulse got %0h exp 0", bus.edge_pulse); end
        checks++; if (bus.any_pulse !== 1'b0) begin errors++; $display("FAIL reset_any got %0h exp 0", bus.any_pulse); end
        checks++; if (bus.first_ch !== 2'd0) begin errors++; $display("FAIL reset_first got %0h exp 0", bus.first_ch); end
        checks++; if (bus.edge_count !== 64'h0) begin errors++; $display("FAIL reset_count got %0h exp 0", bus.edge_count); end
        checks++; if (bus.missed !== 4'h0) begin errors++; $display("FAIL reset_missed got %0h exp 0", bus.missed); end
        // Rising edge on ch0: sync_out after the 3rd edge, pulse after the 5th.
        bus.async_in[0] = 1'b1;
        step(3);
        checks++; if (bus.sync_out !== 4'h1) begin errors++; $display("FAIL lat_sync got %0h exp 1", bus.sync_out); end
        step(1);
        checks++; if (bus.edge_pulse !== 4'h0) begin errors++; $display("FAIL lat_early got %0h exp 0", bus.edge_pulse); end
        step(1);
        checks++; if (bus.edge_pulse !== 4'h1) begin errors++; $display("FAIL lat_pulse got %0h exp 1", bus.edge_pulse); end
        checks++; if (bus.filt_out !== 4'h1) begin errors++; $display("FAIL lat_filt got %0h exp 1", bus.filt_out); end
        checks++; if (bus.edge_count[15:0] !== 16'd1) begin errors++; $display("FAIL lat_count got %0d exp 1", bus.edge_count[15:0]); end
        checks++; if (bus.first_ch !== 2'd0 || bus.any_pulse !== 1'b1) begin errors++; $display("FAIL lat_first got %0h/%0h exp 0/1", bus.first_ch, bus.any_pulse); end
        step(1);
        checks++; if (bus.edge_pulse !== 4'h0) begin errors++; $display("FAIL lat_oneshot got %0h exp 0", bus.edge_pulse); end
    endtask

    task automatic test_glitch();
        bus.async_in[1] = 1'b1;
        step(1);
        bus.async_in[1] = 1'b0;
        step(8);
        checks++; if (bus.edge_count[31:16] !== 16'd0) begin errors++; $display("FAIL glitch1_count got %0d exp 0", bus.edge_count[31:16]); end
        checks++; if (bus.filt_out[1] !== 1'b0) begin errors++; $display("FAIL glitch1_filt got %0h exp 0", bus.filt_out[1]); end
        // 2-cycle excursion, rising only selected.
        bus.async_in[1] = 1'b1;
        step(2);
        bus.async_in[1] = 1'b0;
        step(3);
        checks++; if (bus.edge_pulse !== 4'h2) begin errors++; $display("FAIL glitch2_pulse got %0h exp 2", bus.edge_pulse); end
        step(6);
        checks++; if (bus.edge_count[31:16] !== 16'd1) begin errors++; $display("FAIL glitch2_count got %0d exp 1", bus.edge_count[31:16]); end
        checks++; if (bus.filt_out[1] !== 1'b0) begin errors++; $display("FAIL glitch2_filt got %0h exp 0", bus.filt_out[1]); end
        // Same excursion with both edges selected.
        bus.edge_type[3:2] = 2'b11;
        bus.async_in[1] = 1'b1;
        step(2);
        bus.async_in[1] = 1'b0;
        step(8);
        checks++; if (bus.edge_count[31:16] !== 16'd3) begin errors++; $display("FAIL glitch_both_count got %0d exp 3", bus.edge_count[31:16]); end
        checks++; if (bus.missed !== 4'h0) begin errors++; $display("FAIL glitch_missed got %0h exp 0", bus.missed); end
    endtask

    task automatic test_holdoff();
        int t[$];
        bus.edge_type[5:4] = 2'b11;
        bus.holdoff_cycles = 16'd10;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if ((cyc % 4) == 0 && cyc <= 24) bus.async_in[2] = ~bus.async_in[2];
            step(1);
            if (bus.edge_pulse[2] === 1'b1) t.push_back(cyc);
        end
        checks++; if (t.size() !== 3) begin errors++; $display("FAIL holdoff_npulses got %0d exp 3", t.size()); end
        if (t.size() == 3) begin
            checks++; if (t[1] - t[0] !== 12) begin errors++; $display("FAIL holdoff_gap1 got %0d exp 12", t[1] - t[0]); end
            checks++; if (t[2] - t[1] !== 12) begin errors++; $display("FAIL holdoff_gap2 got %0d exp 12", t[2] - t[1]); end
        end
        checks++; if (bus.edge_count[47:32] !== 16'd3) begin errors++; $display("FAIL holdoff_count got %0d exp 3", bus.edge_count[47:32]); end
        checks++; if (bus.missed !== 4'h4) begin errors++; $display("FAIL holdoff_missed got %0h exp 4", bus.missed); end
        bus.holdoff_cycles = '0;
    endtask

    task automatic test_simultaneous();
        bus.async_in[1] = 1'b1;
        bus.async_in[3] = 1'b1;
        step(4);
        checks++; if (bus.any_pulse !== 1'b0) begin errors++; $display("FAIL simul_early got %0h exp 0", bus.any_pulse); end
        step(1);
        checks++; if (bus.edge_pulse !== 4'ha) begin errors++; $display("FAIL simul_pulse got %0h exp a", bus.edge_pulse); end
        checks++; if (bus.any_pulse !== 1'b1) begin errors++; $display("FAIL simul_any got %0h exp 1", bus.any_pulse); end
        checks++; if (bus.first_ch !== 2'd1) begin errors++; $display("FAIL simul_first got %0h exp 1", bus.first_ch); end
        step(1);
        checks++; if (bus.first_ch !== 2'd0 || bus.any_pulse !== 1'b0) begin errors++; $display("FAIL simul_after got %0h/%0h exp 0/0", bus.first_ch, bus.any_pulse); end
    endtask

    task automatic test_edge_type_change();
        bus.edge_type = 8'hff;
        step(6);
        checks++; if (bus.edge_count[15:0] !== 16'd1) begin errors++; $display("FAIL etype_count got %0d exp 1", bus.edge_count[15:0]); end
    endtask

    task automatic test_clear();
        bus.async_in[0] = 1'b0;
        step(4);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        checks++; if (bus.edge_pulse !== 4'h1) begin errors++; $display("FAIL clear_pulse got %0h exp 1", bus.edge_pulse); end
        checks++; if (bus.edge_count !== 64'h0) begin errors++; $display("FAIL clear_count got %0h exp 0", bus.edge_count); end
        checks++; if (bus.missed !== 4'h0) begin errors++; $display("FAIL clear_missed got %0h exp 0", bus.missed); end
        step(1);
        checks++; if (bus.edge_count[15:0] !== 16'd0) begin errors++; $display("FAIL clear_hold got %0d exp 0", bus.edge_count[15:0]); end
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 5; k++) begin
            sb.async_in[0] = 1'b1;
            step(6);
            checks++;
            if (sb.edge_count[1:0] !== ((k > 3) ? 2'd3 : 2'(k))) begin
                errors++; $display("FAIL sat_count_%0d got %0d exp %0d", k, sb.edge_count[1:0], (k > 3) ? 3 : k);
            end
            sb.async_in[0] = 1'b0;
            step(6);
        end
    endtask

    task automatic test_reset_mid();
        bus.holdoff_cycles = 16'd10;
        bus.async_in[2] = ~bus.async_in[2];
        step(5);
        checks++; if (bus.edge_pulse !== 4'h4) begin errors++; $display("FAIL rmid_pulse got %0h exp 4", bus.edge_pulse); end
        bus.async_in[2] = ~bus.async_in[2];
        step(3);
        rst_n = 1'b0;
        bus.async_in[2] = ~bus.async_in[2];
        step(1);
        checks++; if (bus.edge_pulse !== 4'h0 || bus.any_pulse !== 1'b0) begin errors++; $display("FAIL rmid_pulse0 got %0h exp 0", bus.edge_pulse); end
        checks++; if (bus.filt_out !== 4'h0 || bus.sync_out !== 4'h0) begin errors++; $display("FAIL rmid_levels got %0h/%0h exp 0/0", bus.filt_out, bus.sync_out); end
        checks++; if (bus.edge_count !== 64'h0 || bus.missed !== 4'h0) begin errors++; $display("FAIL rmid_count got %0h/%0h exp 0/0", bus.edge_count, bus.missed); end
        bus.async_in[2] = ~bus.async_in[2];
        step(1);
        bus.async_in = 4'h4;
        rst_n = 1'b1;
        step(4);
        checks++; if (bus.edge_pulse !== 4'h0) begin errors++; $display("FAIL rmid_early got %0h exp 0", bus.edge_pulse); end
        step(1);
        checks++; if (bus.edge_pulse !== 4'h4) begin errors++; $display("FAIL rmid_rise got %0h exp 4", bus.edge_pulse); end
        checks++; if (bus.edge_count[47:32] !== 16'd1) begin errors++; $display("FAIL rmid_count1 got %0d exp 1", bus.edge_count[47:32]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_glitch();
        test_holdoff();
        test_simultaneous();
        test_edge_type_change();
        test_clear();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdc_edge_detect_mc.md
# cdc_edge_detect_mc

Multi-channel successor to the single-input trigger edge detector. Synchronises `NUM_CH` asynchronous trigger inputs into `clk`, rejects glitches shorter than a parametrised filter length, and emits one-cycle edge pulses per channel with per-channel edge selection and a shared post-edge holdoff window. Each channel also keeps a saturating edge counter and a sticky missed-edge flag. The block sits between the external trigger pins and the delay/arming logic, which consumes `any_pulse`/`first_ch`.

## Interface
- `NUM_CH`, 4, number of trigger channels (≥1)
- `SYNC_STAGES`, 3, synchroniser flops per channel (≥2)
- `FILTER_LEN`, 2, consecutive stable cycles required to accept a level change (≥1)
- `HOLDOFF_W`, 16, width of holdoff count
- `CNT_W`, 16, width of per-channel edge counter
- `clk`  in  1  sole clock
- `rst_n`  in  1  synchronous, active-low reset
- `async_in`  in  NUM_CH  asynchronous trigger inputs
- `edge_type`  in  2*NUM_CH  per-channel select, channel i at [2i+1:2i]; 00 none, 01 rising, 10 falling, 11 both
- `holdoff_cycles`  in  HOLDOFF_W  suppression window after each emitted pulse; 0 disables
- `clear`  in  1  synchronous clear of counters and missed flags
- `sync_out`  out  NUM_CH  last synchroniser stage per channel
- `filt_out`  out  NUM_CH  filtered, accepted level per channel
- `edge_pulse`  out  NUM_CH  registered one-cycle pulse per qualifying edge
- `any_pulse`  out  1  OR of `edge_pulse`
- `first_ch`  out  max(1,$clog2(NUM_CH))  lowest index with `edge_pulse` set; 0 when `any_pulse`=0
- `edge_count`  out  CNT_W*NUM_CH  per-channel emitted-pulse count, channel i at [CNT_W*(i+1)-1:CNT_W*i]
- `missed`  out  NUM_CH  sticky: a qualifying edge was suppressed by holdoff

## Operation
- Reset (`rst_n`=0 at a clk edge): sync chains, `filt_out`, filter counters, holdoff counters, `edge_pulse`, `edge_count`, `missed` all 0. Hence `any_pulse`=0 and `first_ch`=0.
- Synchroniser: shift register of `SYNC_STAGES` per channel; `sync_out` = final stage.
- Filter, per channel: `fcnt` counts cycles with `sync_out`≠`filt_out`. It resets to 0 on any cycle with equality.
  - When mismatch holds and `fcnt`==FILTER_LEN-1, this is a toggle event: `filt_out` takes `sync_out` and `fcnt` returns to 0.
  - Direction of the toggle is the new `filt_out` value: 1 = rising, 0 = falling.
- Qualification: a toggle qualifies if `edge_type` selects its direction. `edge_type` is sampled in the toggle cycle; changing it never creates a pulse.
- Holdoff, per channel: `hcnt` is loaded with `holdoff_cycles` when a pulse is emitted, then decrements to 0.
  - A qualifying toggle while `hcnt`≠0 is suppressed: no pulse, no count. `missed` is set, `filt_out` still updates.
- Emission: a qualifying, unsuppressed toggle sets `edge_pulse[i]`=1 for exactly one cycle, coincident with the `filt_out` update, and increments `edge_count[i]`.
  - The counter saturates at all-ones.
  - `clear` has priority over increment and set: a same-cycle clear yields count 0 and `missed` 0.
- `any_pulse`/`first_ch` are combinational from the registered `edge_pulse`.
- If an input is high at reset release, a rising toggle is reported after the normal latency.

## Timing
- Edge latency: async change captured at edge E0 → `sync_out` changes after edge E0+SYNC_STAGES-1 → `filt_out`/`edge_pulse` change after edge E0+SYNC_STAGES+FILTER_LEN-1.
  - Defaults: pulse visible after the 5th edge counting E0.
- Glitch rejection: a `sync_out` excursion lasting < FILTER_LEN cycles produces no toggle.
- Pulse spacing: pulses on one channel are ≥ max(FILTER_LEN, holdoff_cycles+1) cycles apart.
  - With holdoff_cycles=H, a toggle H cycles after a pulse is suppressed; at H+1 cycles it is emitted.
- Channels are independent. Simultaneous pulses on several channels are all asserted; `first_ch` reports the lowest index.
- Reset asserted mid-holdoff or mid-filter aborts the operation; outputs return to 0 on the next edge. No pulse is emitted in the reset cycle.

## Test plan
- Reset: drive `async_in`=0, release `rst_n` → all outputs 0. Raise ch0 (edge_type 01, defaults) → `edge_pulse[0]` high one cycle after the 5th edge, `edge_count[0]`=1, `first_ch`=0.
- Glitch: 1-cycle high pulse on `sync_out` ch1 with FILTER_LEN=2 → no pulse. 2-cycle high → one rising pulse, then one falling pulse only if edge_type=11.
- Holdoff: holdoff_cycles=10, ch2 toggling every 4 cycles, edge_type=11 → pulses 12 cycles apart, `missed[2]`=1, count increases by 1 per pulse.
- Simultaneous: ch1 and ch3 rise on the same cycle → `edge_pulse`=4'b1010, `any_pulse`=1, `first_ch`=1.
- Saturation/clear: CNT_W=2, 5 rising edges → count=3. `clear` coincident with a pulse → count 0, `missed` 0.
- Reset mid-operation: assert `rst_n`=0 during holdoff with input toggling → next cycle all outputs 0. After release, input high → one rising pulse after latency.
